arf_source_fifo: RTL

Synthesizable responder for the dataflow req/ack pull handshake. It buffers words pushed by a host-side valid/ready stream and answers `req` from an arf graph input (the `din_req_N`/`din_ack_N`/`din_N` triple) with single-cycle `ack` pulses carrying the next word. It replaces the simulation-only producer when an arf graph is placed in real hardware. It is the supplying end of the same protocol that `async_operator` drives.

---
 rtl/arf_pkg.sv | 17 +
 rtl/arf_fifo_mem.sv | 27 ++
 rtl/arf_source_fifo.sv | 108 ++++++++++
 3 files changed

// File: rtl/arf_pkg.sv
// Shared definitions for the arf hardware blocks: default word width and a
// width helper usable in constant expressions.
package arf_pkg;

    localparam int ARF_DATA_WIDTH_DEFAULT = 32;

    // Smallest w such that 2**w >= value; returns 0 for value <= 1.
    function automatic int arf_clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/arf_fifo_mem.sv
// Storage array for arf_source_fifo: one synchronous write port and one
// asynchronous read port.
module arf_fifo_mem #(
    parameter int data_width = 32,
    parameter int depth      = 8,
    parameter int addr_width = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic [addr_width-1:0] rd_addr,
    output logic [data_width-1:0] rd_data
);

    logic [data_width-1:0] mem_q [depth];

    // Contents need no reset; occupancy tracking in the parent masks stale words.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/arf_source_fifo.sv
// Host-fed FIFO that answers an arf graph input's req with single-cycle ack
// pulses, presenting the next buffered word on dout.
module arf_source_fifo
    import arf_pkg::*;
#(
    parameter int                    data_width    = ARF_DATA_WIDTH_DEFAULT,
    parameter int                    depth         = 8,
    parameter logic [data_width-1:0] initial_value = '0,
    localparam int                   ptr_w         = arf_clog2(depth),
    localparam int                   lvl_w         = ptr_w + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [data_width-1:0] wr_data,
    input  logic                  req,
    output logic                  ack,
    output logic [data_width-1:0] dout,
    output logic [31:0]           count,
    output logic [lvl_w-1:0]      level
);

    logic [ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
    logic [lvl_w-1:0]      level_q, level_d;
    logic                  ack_q, ack_d;
    logic [data_width-1:0] dout_q, dout_d;
    logic [31:0]           count_q, count_d;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [data_width-1:0] rd_data;

    arf_fifo_mem #(
        .data_width (data_width),
        .depth      (depth),
        .addr_width (ptr_w)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    // Push is gated by the pre-edge full flag, so a pop cannot make room in the same cycle.
    always_comb begin
        full  = (level_q == lvl_w'(depth));
        empty = (level_q == '0);
        push  = wr_valid & ~full;
        pop   = req & ~ack_q & ~empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ack_d    = 1'b0;
        dout_d   = dout_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_w'(1);
        end

        if (pop) begin
            ack_d    = 1'b1;
            dout_d   = rd_data;
            rd_ptr_d = rd_ptr_q + ptr_w'(1);
            count_d  = count_q + 32'd1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + lvl_w'(1);
            2'b01:   level_d = level_q - lvl_w'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ack_q    <= 1'b0;
            dout_q   <= initial_value;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ack_q    <= ack_d;
            dout_q   <= dout_d;
            count_q  <= count_d;
        end
    end

    assign wr_ready = ~full;
    assign ack      = ack_q;
    assign dout     = dout_q;
    assign count    = count_q;
    assign level    = level_q;

endmodule
